// File: rtl/xcver_rst_ctrl.sv
// xcver_rst_ctrl: SGMII transceiver power-down / digital-reset sequencer with lock, sync and timeout recovery.
module xcver_rst_ctrl #(
    parameter int pPwrDwnCycles = 16,
    parameter int pLockStable   = 8,
    parameter int pLockTimeout  = 65535,
    parameter int pDigRstCycles = 32,
    parameter int pSyncTimeout  = 65535,
    parameter int pLossFilter   = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Enable,
    input  logic       i_PllLocked,
    input  logic       i_Reconfiguring,
    input  logic       i_SignalDetect,
    output logic       o_GxBPwrDwn,
    output logic       o_XcverDigitalRst,
    output logic       o_LinkReady,
    output logic [2:0] o3_State,
    output logic [7:0] o8_RetryCount,
    output logic       o_TimeoutPulse
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PWRDWN    = 3'd1,
        WAIT_LOCK = 3'd2,
        DIG_RST   = 3'd3,
        WAIT_SYNC = 3'd4,
        READY     = 3'd5
    } state_t;

    localparam logic [19:0] PwrDwnLast = 20'(pPwrDwnCycles - 1);
    localparam logic [19:0] LockLast   = 20'(pLockTimeout - 1);
    localparam logic [19:0] DigRstLast = 20'(pDigRstCycles - 1);
    localparam logic [19:0] SyncLast   = 20'(pSyncTimeout - 1);
    localparam logic [19:0] StableN    = 20'(pLockStable);
    localparam logic [19:0] LossN      = 20'(pLossFilter);

    // bit 0 lock, bit 1 reconfig busy, bit 2 rx sync
    logic [2:0]  meta_q, sync_q;
    state_t      state_q, state_d;
    logic [19:0] timer_q, timer_d, stable_q, stable_d, loss_q, loss_d;
    logic [7:0]  retry_q, retry_d;
    logic        pulse_q, pulse_d, pwrdwn_q, pwrdwn_d, digrst_q, digrst_d, ready_q, ready_d;
    logic        lock_s, busy_s, sync_s, stable_ok, entry;

    assign lock_s = sync_q[0];
    assign busy_s = sync_q[1];
    assign sync_s = sync_q[2];

    always_comb begin
        stable_ok = lock_s & ~busy_s;
        state_d   = state_q;
        pulse_d   = 1'b0;
        if (!i_Enable)
            state_d = IDLE;
        else if (!lock_s && (state_q == DIG_RST || state_q == WAIT_SYNC || state_q == READY))
            state_d = WAIT_LOCK;
        else
            case (state_q)
                IDLE:      state_d = PWRDWN;
                PWRDWN:    state_d = (timer_q == PwrDwnLast) ? WAIT_LOCK : PWRDWN;
                WAIT_LOCK: begin
                    if (stable_ok && stable_q + 20'd1 == StableN)
                        state_d = DIG_RST;
                    else if (timer_q == LockLast) begin
                        state_d = PWRDWN;
                        pulse_d = 1'b1;
                    end
                end
                DIG_RST:   state_d = (timer_q == DigRstLast) ? WAIT_SYNC : DIG_RST;
                WAIT_SYNC: begin
                    if (sync_s)
                        state_d = READY;
                    else if (timer_q == SyncLast) begin
                        state_d = DIG_RST;
                        pulse_d = 1'b1;
                    end
                end
                READY:     state_d = (!sync_s && loss_q + 20'd1 == LossN) ? DIG_RST : READY;
                default:   state_d = IDLE;
            endcase
        entry    = state_d != state_q;
        timer_d  = entry ? 20'd0 : timer_q + 20'd1;
        stable_d = (entry || !stable_ok || state_q != WAIT_LOCK) ? 20'd0 : stable_q + 20'd1;
        loss_d   = (entry || sync_s || state_q != READY) ? 20'd0 : loss_q + 20'd1;
        retry_d  = (pulse_d && retry_q != 8'hFF) ? retry_q + 8'd1 : retry_q;
        pwrdwn_d = state_d == IDLE || state_d == PWRDWN;
        digrst_d = state_d <= DIG_RST;
        ready_d  = state_d == READY;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            meta_q   <= 3'd0;
            sync_q   <= 3'd0;
            state_q  <= IDLE;
            timer_q  <= 20'd0;
            stable_q <= 20'd0;
            loss_q   <= 20'd0;
            retry_q  <= 8'd0;
            pulse_q  <= 1'b0;
            pwrdwn_q <= 1'b1;
            digrst_q <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            meta_q   <= {i_SignalDetect, i_Reconfiguring, i_PllLocked};
            sync_q   <= meta_q;
            state_q  <= state_d;
            timer_q  <= timer_d;
            stable_q <= stable_d;
            loss_q   <= loss_d;
            retry_q  <= retry_d;
            pulse_q  <= pulse_d;
            pwrdwn_q <= pwrdwn_d;
            digrst_q <= digrst_d;
            ready_q  <= ready_d;
        end
    end

    assign o_GxBPwrDwn       = pwrdwn_q;
    assign o_XcverDigitalRst = digrst_q;
    assign o_LinkReady       = ready_q;
    assign o3_State          = state_q;
    assign o8_RetryCount     = retry_q;
    assign o_TimeoutPulse    = pulse_q;
endmodule

// File: tb/tb_xcver_rst_ctrl.sv
// tb_xcver_rst_ctrl: directed bench for the transceiver reset sequencer.
module tb_xcver_rst_ctrl;
    logic       clk = 1'b0, rst = 1'b1, en = 1'b0, lock = 1'b0, busy = 1'b0, sig = 1'b0;
    logic       pd, dr, rdy, pulse;
    logic [2:0] st;
    logic [7:0] rc;
    int         errors = 0, checks = 0;
    logic [7:0] seq1 [14] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2,
                              8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd4, 8'd5};

    xcver_rst_ctrl #(
        .pPwrDwnCycles(4), .pLockStable(3), .pLockTimeout(20),
        .pDigRstCycles(5), .pSyncTimeout(30), .pLossFilter(3)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_PllLocked(lock),
        .i_Reconfiguring(busy), .i_SignalDetect(sig),
        .o_GxBPwrDwn(pd), .o_XcverDigitalRst(dr), .o_LinkReady(rdy),
        .o3_State(st), .o8_RetryCount(rc), .o_TimeoutPulse(pulse)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_state"}, 8'(st), 8'd0);
        chk({tag, "_pwrdwn"}, 8'(pd), 8'd1);
        chk({tag, "_digrst"}, 8'(dr), 8'd1);
        chk({tag, "_ready"}, 8'(rdy), 8'd0);
        chk({tag, "_retry"}, rc, 8'd0);
        chk({tag, "_pulse"}, 8'(pulse), 8'd0);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] exp, input int budget);
        int n = 0;
        while (st !== exp && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 8'(st), 8'(exp));
    endtask

    initial begin
        step(3);
        chk_rst("reset");
        rst = 1'b0;
        step(1);
        chk_rst("post_reset");

        en = 1'b1; lock = 1'b1; sig = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step(1);
            chk($sformatf("bringup_%0d", i), 8'(st), seq1[i]);
        end
        chk("bringup_ready", 8'(rdy), 8'd1);
        chk("bringup_pwrdwn", 8'(pd), 8'd0);
        chk("bringup_digrst", 8'(dr), 8'd0);
        chk("bringup_retry", rc, 8'd0);

        sig = 1'b0;
        step(2);
        sig = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("loss2_hold", 8'(st), 8'd5);
        end
        sig = 1'b0;
        step(3);
        sig = 1'b1;
        step(1);
        chk("loss3_pre", 8'(st), 8'd5);
        step(1);
        chk("loss3_state", 8'(st), 8'd3);
        chk("loss3_ready", 8'(rdy), 8'd0);
        chk("loss3_retry", rc, 8'd0);
        wait_state("loss3_recover", 3'd5, 20);

        lock = 1'b0;
        step(2);
        chk("lockloss_pre_state", 8'(st), 8'd5);
        chk("lockloss_pre_digrst", 8'(dr), 8'd0);
        step(1);
        chk("lockloss_state", 8'(st), 8'd2);
        chk("lockloss_digrst", 8'(dr), 8'd1);
        chk("lockloss_retry", rc, 8'd0);

        lock = 1'b1;
        step(2);
        busy = 1'b1;
        step(1);
        busy = 1'b0;
        step(1);
        chk("glitch_e4", 8'(st), 8'd2);
        step(1);
        chk("glitch_e5", 8'(st), 8'd2);
        step(2);
        chk("glitch_e7", 8'(st), 8'd2);
        step(1);
        chk("glitch_e8", 8'(st), 8'd3);
        wait_state("glitch_recover", 3'd5, 20);

        sig = 1'b0;
        wait_state("synctmo_enter", 3'd4, 30);
        step(29);
        chk("synctmo_pre_state", 8'(st), 8'd4);
        chk("synctmo_pre_pulse", 8'(pulse), 8'd0);
        step(1);
        chk("synctmo_state", 8'(st), 8'd3);
        chk("synctmo_pulse", 8'(pulse), 8'd1);
        chk("synctmo_retry", rc, 8'd1);
        step(1);
        chk("synctmo_pulse_end", 8'(pulse), 8'd0);
        wait_state("synctmo_reenter", 3'd4, 10);
        step(29);
        en = 1'b0;
        step(1);
        chk("disable_state", 8'(st), 8'd0);
        chk("disable_pulse", 8'(pulse), 8'd0);
        chk("disable_retry", rc, 8'd1);
        chk("disable_pwrdwn", 8'(pd), 8'd1);

        en = 1'b1;
        wait_state("rst_reach_digrst", 3'd3, 40);
        rst = 1'b1;
        step(1);
        chk_rst("rst_in_digrst");
        rst = 1'b0; en = 1'b0; lock = 1'b0;
        step(1);

        en = 1'b1;
        step(24);
        chk("nolock_wait_state", 8'(st), 8'd2);
        chk("nolock_wait_pulse", 8'(pulse), 8'd0);
        for (int k = 1; k <= 3; k++) begin
            step(1);
            chk($sformatf("nolock_%0d_state", k), 8'(st), 8'd1);
            chk($sformatf("nolock_%0d_pulse", k), 8'(pulse), 8'd1);
            chk($sformatf("nolock_%0d_retry", k), rc, 8'(k));
            step(1);
            chk($sformatf("nolock_%0d_pulse_end", k), 8'(pulse), 8'd0);
            step(22);
        end
        step(7105);
        chk("sat_state", 8'(st), 8'd1);
        chk("sat_pulse", 8'(pulse), 8'd1);
        chk("sat_retry", rc, 8'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
